blend_weight_seq: RTL
=====================

# blend_weight_seq

Sequential, handshaked generator of the static/flat blend weight pair (w_s, w_f) used by the CFA interpolation blend stage. It compares the absolute difference `diff` against two blend thresholds. In-range samples get a fractional weight from an iterative radix-2 divider, one quotient bit per cycle. Weight width is a parameter. The block sits between the gradient/difference stage and the pixel blender, replacing the purely combinational weight path with a small valid/ready unit.

## Interface
- PIXEL_BW, 12, pixel bit width; `diff` is PIXEL_BW+1 bits; PIXEL_BW+1 >= TH_BW required
- TH_BW, 9, threshold bit width
- W_BW, 8, weight bit width; full scale S = 2^W_BW − 1
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- diff  in  PIXEL_BW+1  unsigned absolute difference
- blend_th0  in  TH_BW  lower threshold, unsigned
- blend_th1  in  TH_BW  upper threshold, unsigned
- out_valid  out  1  weights valid
- out_ready  in  1  downstream accepts weights
- w_s  out  W_BW  static-direction weight
- w_f  out  W_BW  flat-direction weight

## Operation
- FSM states: IDLE, DIV, DONE. The reset state is IDLE.
- Accept occurs when in_valid && in_ready. in_ready = (state==IDLE) && !rst.
- On accept, latch diff, blend_th0 and blend_th1. Compare with the thresholds zero-extended to PIXEL_BW+1 bits:
  - lt = diff < th0
  - gt = diff > th1
- Case {gt,lt} = 01: w_s=S, w_f=0. Go to DONE.
- Case {gt,lt} = 10: w_s=0, w_f=S. Go to DONE.
- Case {gt,lt} = 11 (only possible when th1 < th0): w_s=0, w_f=0. Go to DONE.
- Case {gt,lt} = 00, in range:
  - n = diff − th0 and d = th1 − th0, both fit TH_BW bits.
  - If d == 0 (th0 == th1 == diff): w_s=S, w_f=0. Go to DONE.
  - Otherwise load remainder r = n (TH_BW+1 bits) and clear the quotient q (W_BW+1 bits). Go to DIV.
- DIV runs W_BW iterations. Each iteration:
  - r ← 2r
  - if r ≥ d then r ← r − d and the quotient bit is 1, else the bit is 0
  - shift the bit into q LSB-first-in
- On the last iteration:
  - q = floor(n·2^W_BW / d), which lies in [0, 2^W_BW].
  - q == 2^W_BW arises from n == d only; it is represented by the initial n == d check, which sets the overflow flag.
  - w_f = min(q, S) and w_s = S − w_f.
  - Go to DONE.
- DONE: out_valid=1. w_s and w_f are held stable. When out_ready=1, go to IDLE and clear out_valid. No new accept occurs in the same cycle.
- Invariant: in range with d ≠ 0, w_s + w_f == S. All other cases use the fixed pairs listed above.
- All arithmetic is unsigned. No input value may cause wrap or X: d=0 and th1<th0 are handled explicitly.

## Timing
- Reset values: state=IDLE, out_valid=0, w_s=0, w_f=0, internal r/q/iteration counter=0. in_ready=0 while rst is high.
- Bypass latency (out-of-range, inverted, or d=0): out_valid rises 1 cycle after the accept edge.
- Division latency: out_valid rises W_BW+1 cycles after the accept edge (9 cycles for defaults).
- Throughput: at most one sample per latency+1 cycles, since IDLE must be re-entered before the next accept.
- Backpressure: while out_valid && !out_ready, outputs and state are frozen and in_ready stays 0.
- Input changes after accept have no effect because the operands are latched.
- rst asserted in any state, including mid-DIV: the result is discarded and the next cycle is IDLE with reset values. No out_valid pulse is produced for the aborted sample.

## Test plan
- Below threshold: th0=20, th1=100, diff=10 → one cycle after accept, w_s=255, w_f=0, out_valid=1.
- Mid range: th0=20, th1=100, diff=60 (n=40, d=80) → w_f=128, w_s=127, out_valid exactly 9 cycles after accept.
- Upper edge and above: diff=100 → w_f=255, w_s=0 (clamped). diff=4000 → 1-cycle bypass, w_s=0, w_f=255.
- Degenerate thresholds:
  - th0=100, th1=20, diff=60 → w_s=0, w_f=0.
  - th0=th1=50, diff=50 → w_s=255, w_f=0 after 1 cycle.
  - th0=th1=50, diff=49 → w_s=255, w_f=0.
- Backpressure: hold out_ready low for 5 cycles in DONE → w_s/w_f/out_valid stable, in_ready=0, and in_valid with changed diff is ignored. Raise out_ready → in_ready=1 on the next cycle.
- Reset mid-DIV: accept diff=60 (th 20/100), assert rst on cycle 4 → out_valid never rises, outputs 0, in_ready=1 the cycle after rst deasserts. A new sample then completes normally.

Source files
------------

// File: rtl/blend_weight_seq.sv
// blend_weight_seq: handshaked generator of the static/flat blend weight pair.
// Out-of-range and degenerate threshold cases produce fixed weights in one
// cycle; in-range samples get w_f = floor(n*2^W_BW/d), clamped to full scale,
// from a restoring radix-2 divider that resolves one quotient bit per cycle.
module blend_weight_seq #(
  parameter int PIXEL_BW = 12,
  parameter int TH_BW    = 9,
  parameter int W_BW     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PIXEL_BW:0]   diff,
  input  logic [TH_BW-1:0]    blend_th0,
  input  logic [TH_BW-1:0]    blend_th1,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W_BW-1:0]     w_s,
  output logic [W_BW-1:0]     w_f
);

  localparam int CNT_BW = (W_BW > 1) ? $clog2(W_BW + 1) : 1;

  typedef logic [PIXEL_BW:0] pix_t;
  typedef logic [CNT_BW-1:0] cnt_t;
  typedef logic [W_BW-1:0]   wgt_t;
  typedef logic [W_BW:0]     quo_t;

  localparam wgt_t S_FULL   = '1;
  localparam cnt_t CNT_LAST = cnt_t'(W_BW - 1);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [TH_BW:0]   r_rem,  w_rem_next;
  quo_t             r_quo,  w_quo_next;
  cnt_t             r_cnt,  w_cnt_next;
  logic [TH_BW-1:0] r_den,  w_den_next;
  logic             r_ovf,  w_ovf_next;
  wgt_t             r_w_s,  w_w_s_next;
  wgt_t             r_w_f,  w_w_f_next;

  // Threshold comparison against the live inputs; only used on the accept cycle.
  pix_t             w_th0_ext;
  pix_t             w_th1_ext;
  logic             w_lt;
  logic             w_gt;
  logic [TH_BW-1:0] w_n;
  logic [TH_BW-1:0] w_d;

  assign w_th0_ext = pix_t'(blend_th0);
  assign w_th1_ext = pix_t'(blend_th1);
  assign w_lt      = (diff < w_th0_ext);
  assign w_gt      = (diff > w_th1_ext);
  // In range means diff <= th1 < 2^TH_BW, so the low TH_BW bits of diff are exact.
  assign w_n       = diff[TH_BW-1:0] - blend_th0;
  assign w_d       = blend_th1 - blend_th0;

  // One restoring-division step. The remainder never exceeds d before the
  // shift, so the doubled value still fits TH_BW+1 bits.
  logic [TH_BW:0] w_rem_sh;
  logic [TH_BW:0] w_den_ext;
  logic           w_qbit;
  logic [TH_BW:0] w_rem_step;
  quo_t           w_q_shift;
  wgt_t           w_q_sat;

  assign w_rem_sh   = r_rem << 1;
  assign w_den_ext  = {1'b0, r_den};
  assign w_qbit     = (w_rem_sh >= w_den_ext);
  assign w_rem_step = w_qbit ? (w_rem_sh - w_den_ext) : w_rem_sh;
  assign w_q_shift  = (r_quo << 1) | quo_t'(w_qbit);
  // n == d would need a quotient of 2^W_BW; the flag pins it to full scale.
  assign w_q_sat    = (r_ovf || w_q_shift[W_BW]) ? S_FULL : w_q_shift[W_BW-1:0];

  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = (r_state == DONE);
  assign w_s       = r_w_s;
  assign w_f       = r_w_f;

  // Next-state and datapath decisions; every register holds by default.
  always_comb begin
    w_state_next = r_state;
    w_rem_next   = r_rem;
    w_quo_next   = r_quo;
    w_cnt_next   = r_cnt;
    w_den_next   = r_den;
    w_ovf_next   = r_ovf;
    w_w_s_next   = r_w_s;
    w_w_f_next   = r_w_f;
    case (r_state)
      IDLE: begin
        if (in_valid && in_ready) begin
          case ({w_gt, w_lt})
            2'b01: begin
              w_w_s_next   = S_FULL;
              w_w_f_next   = '0;
              w_state_next = DONE;
            end
            2'b10: begin
              w_w_s_next   = '0;
              w_w_f_next   = S_FULL;
              w_state_next = DONE;
            end
            2'b11: begin
              // Only reachable with inverted thresholds (th1 < th0).
              w_w_s_next   = '0;
              w_w_f_next   = '0;
              w_state_next = DONE;
            end
            default: begin
              if (w_d == '0) begin
                w_w_s_next   = S_FULL;
                w_w_f_next   = '0;
                w_state_next = DONE;
              end else begin
                w_rem_next   = {1'b0, w_n};
                w_quo_next   = '0;
                w_cnt_next   = '0;
                w_den_next   = w_d;
                w_ovf_next   = (w_n == w_d);
                w_state_next = DIV;
              end
            end
          endcase
        end
      end
      DIV: begin
        w_rem_next = w_rem_step;
        w_quo_next = w_q_shift;
        w_cnt_next = r_cnt + cnt_t'(1);
        if (r_cnt == CNT_LAST) begin
          w_w_f_next   = w_q_sat;
          w_w_s_next   = S_FULL - w_q_sat;
          w_state_next = DONE;
        end
      end
      DONE: begin
        // Returning to IDLE first means no accept can share this cycle.
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State register; reset aborts any sample in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath and output weight registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem <= '0;
      r_quo <= '0;
      r_cnt <= '0;
      r_den <= '0;
      r_ovf <= 1'b0;
      r_w_s <= '0;
      r_w_f <= '0;
    end else begin
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
      r_cnt <= w_cnt_next;
      r_den <= w_den_next;
      r_ovf <= w_ovf_next;
      r_w_s <= w_w_s_next;
      r_w_f <= w_w_f_next;
    end
  end

endmodule
